// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the byte-wide RAM port between instruction fetch, LSB loads
// and ROB-committed stores; serialises each access into byte transfers.
`ifndef LB
`define LB  6'd1
`define LH  6'd2
`define LW  6'd3
`define LBU 6'd4
`define LHU 6'd5
`define SB  6'd6
`define SH  6'd7
`define SW  6'd8
`endif

module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] IO_ADDR = 32'h30000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  input  logic              load_store_sgn,
  input  logic [5:0]        load_store_op,
  input  logic [ADDR_W-1:0] load_store_addr,
  output logic              begin_real_load,
  output logic              mem_valid,
  output logic [31:0]       mem_res,
  input  logic              store_commit,
  input  logic [5:0]        store_op,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic [31:0]       store_data,
  output logic              finish_store
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

  state_t            state;
  logic [2:0]        idx;
  logic [2:0]        nbytes;
  logic [ADDR_W-1:0] base;
  logic [5:0]        ld_op;
  logic [31:0]       rd_buf;
  logic [31:0]       rd_word;

  logic              st_pend;
  logic [5:0]        st_op;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic              io_stall;

  function automatic logic [2:0] op_bytes(input logic [5:0] op);
    case (op)
      `LB, `LBU, `SB: op_bytes = 3'd1;
      `LH, `LHU, `SH: op_bytes = 3'd2;
      default:        op_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [5:0] op, input logic [31:0] w);
    case (op)
      `LB:     extend = {{24{w[7]}}, w[7:0]};
      `LH:     extend = {{16{w[15]}}, w[15:0]};
      `LBU:    extend = {24'd0, w[7:0]};
      `LHU:    extend = {16'd0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  function automatic logic [7:0] st_byte(input logic [31:0] d, input logic [2:0] i);
    case (i)
      3'd0:    st_byte = d[7:0];
      3'd1:    st_byte = d[15:8];
      3'd2:    st_byte = d[23:16];
      default: st_byte = d[31:24];
    endcase
  endfunction

  assign io_stall = io_buffer_full && (st_addr >= IO_ADDR);

  // The last byte is taken straight from mem_din in the cycle the result is returned.
  always_comb begin
    rd_word = rd_buf;
    case (nbytes)
      3'd1:    rd_word[7:0]   = mem_din;
      3'd2:    rd_word[15:8]  = mem_din;
      default: rd_word[31:24] = mem_din;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= 3'd0;
      nbytes          <= 3'd0;
      base            <= '0;
      ld_op           <= 6'd0;
      rd_buf          <= 32'd0;
      mem_a           <= '0;
      mem_dout        <= 8'd0;
      mem_wr          <= 1'b0;
      if_valid        <= 1'b0;
      if_inst         <= 32'd0;
      begin_real_load <= 1'b0;
      mem_valid       <= 1'b0;
      mem_res         <= 32'd0;
      finish_store    <= 1'b0;
      st_pend         <= 1'b0;
      st_op           <= 6'd0;
      st_addr         <= '0;
      st_data         <= 32'd0;
    end else if (rdy) begin
      if_valid        <= 1'b0;
      mem_valid       <= 1'b0;
      begin_real_load <= 1'b0;
      finish_store    <= 1'b0;

      if (store_commit) begin
        st_pend <= 1'b1;
        st_op   <= store_op;
        st_addr <= store_addr;
        st_data <= store_data;
      end

      case (state)
        IDLE: begin
          idx    <= 3'd0;
          rd_buf <= 32'd0;
          if (st_pend) begin
            state    <= STORE;
            st_pend  <= 1'b0;
            nbytes   <= op_bytes(st_op);
            base     <= st_addr;
            mem_a    <= st_addr;
            mem_dout <= st_data[7:0];
            mem_wr   <= !io_stall;
          end else if (load_store_sgn) begin
            state           <= LOAD;
            ld_op           <= load_store_op;
            nbytes          <= op_bytes(load_store_op);
            base            <= load_store_addr;
            mem_a           <= load_store_addr;
            mem_wr          <= 1'b0;
            begin_real_load <= 1'b1;
          end else if (if_req) begin
            state  <= FETCH;
            nbytes <= 3'd4;
            base   <= if_addr;
            mem_a  <= if_addr;
            mem_wr <= 1'b0;
          end else begin
            mem_a  <= '0;
            mem_wr <= 1'b0;
          end
        end

        FETCH, LOAD: begin
          if (rollback) begin
            state <= IDLE;
            mem_a <= '0;
          end else if (idx == nbytes) begin
            state <= IDLE;
            mem_a <= '0;
            if (state == FETCH) begin
              if_valid <= 1'b1;
              if_inst  <= rd_word;
            end else begin
              mem_valid <= 1'b1;
              mem_res   <= extend(ld_op, rd_word);
            end
          end else begin
            case (idx)
              3'd1:    rd_buf[7:0]   <= mem_din;
              3'd2:    rd_buf[15:8]  <= mem_din;
              3'd3:    rd_buf[23:16] <= mem_din;
              default: ;
            endcase
            idx <= idx + 3'd1;
            if ((idx + 3'd1) < nbytes)
              mem_a <= base + ADDR_W'(idx + 3'd1);
          end
        end

        // Committed stores ignore rollback; a stalled IO cycle keeps the byte index.
        STORE: begin
          if (mem_wr) begin
            if ((idx + 3'd1) == nbytes) begin
              state        <= IDLE;
              finish_store <= 1'b1;
              mem_wr       <= 1'b0;
              mem_a        <= '0;
            end else begin
              idx      <= idx + 3'd1;
              mem_a    <= base + ADDR_W'(idx + 3'd1);
              mem_dout <= st_byte(st_data, idx + 3'd1);
              mem_wr   <= !io_stall;
            end
          end else begin
            mem_wr <= !io_stall;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed stimulus pushes expected RAM-port events
// and handshake pulses; a negedge monitor pops and compares them as they appear.
`ifndef LB
`define LB  6'd1
`define LH  6'd2
`define LW  6'd3
`define LBU 6'd4
`define LHU 6'd5
`define SB  6'd6
`define SH  6'd7
`define SW  6'd8
`endif

module tb_mem_ctrl;
  localparam logic [31:0] IO_ADDR = 32'h30000;
  localparam int K_FIN = 0, K_IFV = 1, K_MV = 2, K_BRL = 3, K_WR = 4, K_AD = 5;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  stall_cnt = 0;
  logic [31:0] prev_a = 32'd0;
  logic        rdy_q = 1'b1;

  logic        clk, rst, rdy, rollback;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;
  logic        if_req, if_valid;
  logic [31:0] if_addr, if_inst;
  logic        load_store_sgn, begin_real_load, mem_valid;
  logic [5:0]  load_store_op, store_op;
  logic [31:0] load_store_addr, mem_res;
  logic        store_commit, finish_store;
  logic [31:0] store_addr, store_data;

  logic [7:0] ram [logic [31:0]];

  mem_ctrl #(.ADDR_W(32), .IO_ADDR(IO_ADDR)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_inst(if_inst),
    .load_store_sgn(load_store_sgn), .load_store_op(load_store_op),
    .load_store_addr(load_store_addr), .begin_real_load(begin_real_load),
    .mem_valid(mem_valid), .mem_res(mem_res),
    .store_commit(store_commit), .store_op(store_op), .store_addr(store_addr),
    .store_data(store_data), .finish_store(finish_store)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read data appears one cycle after the address.
  always @(posedge clk) begin
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    if (mem_wr) ram[mem_a] = mem_dout;
    rdy_q <= rdy;
  end

  function automatic string kname(input int k);
    case (k)
      K_FIN:   kname = "finish_store";
      K_IFV:   kname = "if_valid";
      K_MV:    kname = "mem_valid";
      K_BRL:   kname = "begin_real_load";
      K_WR:    kname = "write";
      default: kname = "read_addr";
    endcase
  endfunction

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic mon_check(input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected: got a=%h d=%h, required no event", kname(k), a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a != a || e.d != d) begin
        failures++;
        $display("FAIL %s: got %s a=%h d=%h, required %s a=%h d=%h",
                 kname(e.kind), kname(k), a, d, kname(e.kind), e.a, e.d);
      end
    end
  endtask

  // Monitor: outputs repeated by an rdy=0 freeze are skipped.
  always @(negedge clk) begin
    if (!rst && rdy_q) begin
      if (finish_store)    mon_check(K_FIN, 32'd0, 32'd0);
      if (if_valid)        mon_check(K_IFV, 32'd0, if_inst);
      if (mem_valid)       mon_check(K_MV, 32'd0, mem_res);
      if (begin_real_load) mon_check(K_BRL, 32'd0, 32'd0);
      if (mem_wr)          mon_check(K_WR, mem_a, {24'd0, mem_dout});
      else if (mem_a != 32'd0 && mem_a != prev_a) mon_check(K_AD, mem_a, 32'd0);
      if (!mem_wr && mem_a == IO_ADDR) stall_cnt++;
      prev_a = mem_a;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s timeout: got %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    store_commit = 1'b1; store_op = op; store_addr = a; store_data = d;
    tick();
    store_commit = 1'b0;
  endtask

  task automatic load(input logic [5:0] op, input logic [31:0] a);
    load_store_sgn = 1'b1; load_store_op = op; load_store_addr = a;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    load_store_sgn = 1'b0; load_store_op = 6'd0; load_store_addr = 32'd0;
    store_commit = 1'b0; store_op = 6'd0; store_addr = 32'd0; store_data = 32'd0;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
    ram[32'h200] = 8'h80;
    ram[32'h210] = 8'h34; ram[32'h211] = 8'h92;

    // Level requests are dropped once the controller acknowledges them.
    fork
      forever begin
        @(posedge clk);
        #1;
        if (begin_real_load) load_store_sgn = 1'b0;
        if (if_valid) if_req = 1'b0;
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_addr", {32'd0, mem_a}, 64'd0);
    chk("rst_ctl", {59'd0, mem_wr, if_valid, begin_real_load, mem_valid, finish_store}, 64'd0);
    chk("rst_data", {if_inst, mem_res}, 64'd0);
    tick();

    // Fetch
    push(K_AD, 32'h100, 0); push(K_AD, 32'h101, 0); push(K_AD, 32'h102, 0); push(K_AD, 32'h103, 0);
    push(K_IFV, 0, 32'h00100513);
    if_req = 1'b1; if_addr = 32'h100;
    drain("fetch", 40);

    // LB sign-extends
    push(K_BRL, 0, 0); push(K_AD, 32'h200, 0); push(K_MV, 0, 32'hFFFFFF80);
    load(`LB, 32'h200);
    drain("lb", 40);

    // LBU zero-extends; pulse held through an rdy=0 cycle
    push(K_BRL, 0, 0); push(K_AD, 32'h200, 0); push(K_MV, 0, 32'h00000080);
    load(`LBU, 32'h200);
    tick(); tick(); tick();
    rdy = 1'b0;
    tick();
    chk("mv_hold", {31'd0, mem_valid, mem_res}, {31'd0, 1'b1, 32'h00000080});
    rdy = 1'b1;
    drain("lbu", 40);

    // SW then LW readback
    push(K_WR, 32'h300, 32'hEF); push(K_WR, 32'h301, 32'hBE);
    push(K_WR, 32'h302, 32'hAD); push(K_WR, 32'h303, 32'hDE); push(K_FIN, 0, 0);
    commit(`SW, 32'h300, 32'hDEADBEEF);
    drain("sw", 40);
    push(K_BRL, 0, 0);
    push(K_AD, 32'h300, 0); push(K_AD, 32'h301, 0); push(K_AD, 32'h302, 0); push(K_AD, 32'h303, 0);
    push(K_MV, 0, 32'hDEADBEEF);
    load(`LW, 32'h300);
    drain("lw", 40);

    // Priority: pending store, then load, then fetch
    push(K_WR, 32'h340, 32'hB2); push(K_WR, 32'h341, 32'hA1); push(K_FIN, 0, 0);
    push(K_BRL, 0, 0); push(K_AD, 32'h210, 0); push(K_AD, 32'h211, 0); push(K_MV, 0, 32'hFFFF9234);
    push(K_AD, 32'h100, 0); push(K_AD, 32'h101, 0); push(K_AD, 32'h102, 0); push(K_AD, 32'h103, 0);
    push(K_IFV, 0, 32'h00100513);
    commit(`SH, 32'h340, 32'h0000A1B2);
    load(`LH, 32'h210);
    if_req = 1'b1; if_addr = 32'h100;
    drain("priority", 80);

    // Rollback in cycle 2 of LW aborts with no mem_valid
    push(K_BRL, 0, 0); push(K_AD, 32'h300, 0); push(K_AD, 32'h301, 0); push(K_AD, 32'h302, 0);
    load(`LW, 32'h300);
    tick(); tick(); tick();
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    chk("rb_idle", {31'd0, mem_wr, mem_a}, 64'd0);
    drain("rb_lw", 20);

    // Rollback during a pending and active SW has no effect
    push(K_WR, 32'h320, 32'h44); push(K_WR, 32'h321, 32'h33);
    push(K_WR, 32'h322, 32'h22); push(K_WR, 32'h323, 32'h11); push(K_FIN, 0, 0);
    commit(`SW, 32'h320, 32'h11223344);
    rollback = 1'b1;
    repeat (4) tick();
    rollback = 1'b0;
    drain("rb_sw", 40);

    // Just below the IO region: never stalls
    stall_cnt = 0;
    push(K_WR, 32'h2FFFF, 32'h77); push(K_FIN, 0, 0);
    io_buffer_full = 1'b1;
    commit(`SB, 32'h2FFFF, 32'h00000077);
    drain("below_io", 20);
    io_buffer_full = 1'b0;

    // IO store stalled three cycles
    stall_cnt = 0;
    push(K_AD, IO_ADDR, 0); push(K_WR, IO_ADDR, 32'h5A); push(K_FIN, 0, 0);
    io_buffer_full = 1'b1;
    commit(`SB, IO_ADDR, 32'h0000005A);
    tick(); tick(); tick();
    io_buffer_full = 1'b0;
    drain("io_stall", 40);
    chk("io_stall_cycles", 64'(stall_cnt), 64'd3);

    // Async reset mid-fetch
    push(K_AD, 32'h100, 0); push(K_AD, 32'h101, 0);
    if_req = 1'b1; if_addr = 32'h100;
    tick(); tick();
    if_req = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_addr", {24'd0, mem_dout, mem_a}, 64'd0);
    chk("arst_ctl", {59'd0, mem_wr, if_valid, begin_real_load, mem_valid, finish_store}, 64'd0);
    chk("arst_data", {if_inst, mem_res}, 64'd0);
    chk("arst_events_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
